// File: rtl/f_alu_pkg.sv
// Shared definitions for the fixed-point ALU: opcodes, FSM states and
// saturation limits at the default operand width.
package f_alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MADD = 3'd3;
  localparam logic [2:0] OP_MSUB = 3'd4;
  localparam logic [2:0] OP_MIN  = 3'd5;
  localparam logic [2:0] OP_MAX  = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [XLEN_DEFAULT-1:0] SAT_MAX = {1'b0, {(XLEN_DEFAULT-1){1'b1}}};
  localparam logic [XLEN_DEFAULT-1:0] SAT_MIN = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/f_fixed_div.sv
// Iterative restoring divider on magnitudes: one quotient bit per clock,
// dividend is the magnitude pre-scaled by FRAC fractional bits.
module f_fixed_div #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FRAC      = 4,
  parameter int unsigned DIV_STEPS = XLEN + FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [XLEN-1:0]      dividend,
  input  logic [XLEN-1:0]      divisor,
  output logic                 done,
  output logic [XLEN+FRAC-1:0] quotient
);

  localparam int unsigned QW = XLEN + FRAC;
  localparam int unsigned CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [QW-1:0]   quo;
  logic [CW-1:0]   count;
  logic            running;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  always_comb begin
    shifted = {rem, quo[QW-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = shifted >= {1'b0, dvs};
  end

  // done flags the edge on which the final quotient bit is written
  assign done     = running && (count == CW'(DIV_STEPS - 1));
  assign quotient = quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
      rem     <= '0;
      dvs     <= '0;
      quo     <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      rem     <= '0;
      dvs     <= divisor;
      quo     <= QW'(dividend) << FRAC;
    end else if (running) begin
      rem   <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo   <= {quo[QW-2:0], fits};
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/f_fixed_alu.sv
// Signed fixed-point ALU behind the FP register file: single-cycle
// add/sub/min/max, two-cycle multiply family, iterative divide.
module f_fixed_alu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned FRAC      = 4,
  parameter int unsigned DIV_STEPS = XLEN + FRAC
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iSTART,
  input  logic [2:0]      iOP,
  input  logic [4:0]      iRD,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic [XLEN-1:0] iC,
  output logic            oBUSY,
  output logic            oDONE,
  output logic [XLEN-1:0] oRESULT,
  output logic [4:0]      oRD,
  output logic            oOV,
  output logic            oDZ
);
  import f_alu_pkg::*;

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned QW = XLEN + FRAC;
  localparam logic [XLEN-1:0] SMAX = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [QW-1:0] LIM_POS = QW'(SMAX);
  localparam logic [QW-1:0] LIM_NEG = QW'(SMIN);

  state_t                 state;
  logic signed [PW-1:0]   prod;
  logic [2:0]             mop;
  logic [XLEN-1:0]        mc;
  logic [4:0]             tag;
  logic                   neg_q;

  logic                   accept, quick, quick_ov, quick_dz, div_start, div_done;
  logic [XLEN-1:0]        quick_val, a_mag, b_mag;
  logic signed [PW-1:0]   a_ext, b_ext, prod_sh;
  logic [PW:0]            msum;
  logic                   mul_ov, fix_ov;
  logic [XLEN-1:0]        mul_val, fix_val;
  logic [QW-1:0]          div_q;

  function automatic logic [XLEN:0] sat_narrow(input logic [XLEN:0] w);
    logic ov;
    ov = w[XLEN] ^ w[XLEN-1];
    return {ov, ov ? (w[XLEN] ? SMIN : SMAX) : w[XLEN-1:0]};
  endfunction

  assign oBUSY  = (state != S_IDLE);
  assign accept = (state == S_IDLE) && iSTART;

  always_comb begin
    quick     = 1'b1;
    quick_ov  = 1'b0;
    quick_dz  = 1'b0;
    quick_val = '0;
    unique case (iOP)
      OP_ADD:  {quick_ov, quick_val} = sat_narrow({iA[XLEN-1], iA} + {iB[XLEN-1], iB});
      OP_SUB:  {quick_ov, quick_val} = sat_narrow({iA[XLEN-1], iA} - {iB[XLEN-1], iB});
      OP_MIN:  quick_val = ($signed(iB) < $signed(iA)) ? iB : iA;
      OP_MAX:  quick_val = ($signed(iA) < $signed(iB)) ? iB : iA;
      OP_DIV:  begin
        if (iB == '0) begin
          quick_dz  = 1'b1;
          quick_val = iA[XLEN-1] ? SMIN : SMAX;
        end else begin
          quick = 1'b0;
        end
      end
      default: quick = 1'b0;
    endcase
  end

  always_comb begin
    a_ext     = {{XLEN{iA[XLEN-1]}}, iA};
    b_ext     = {{XLEN{iB[XLEN-1]}}, iB};
    a_mag     = iA[XLEN-1] ? -iA : iA;
    b_mag     = iB[XLEN-1] ? -iB : iB;
    div_start = accept && (iOP == OP_DIV) && !quick;
  end

  // Product keeps full precision until the shift, so truncation is toward -inf
  always_comb begin
    prod_sh = prod >>> FRAC;
    msum    = {prod_sh[PW-1], prod_sh};
    if (mop == OP_MADD)      msum = msum + {{(PW+1-XLEN){mc[XLEN-1]}}, mc};
    else if (mop == OP_MSUB) msum = msum - {{(PW+1-XLEN){mc[XLEN-1]}}, mc};
    mul_ov  = !((msum[PW:XLEN-1] == '0) || (msum[PW:XLEN-1] == '1));
    mul_val = mul_ov ? (msum[PW] ? SMIN : SMAX) : msum[XLEN-1:0];
  end

  // A negative quotient may reach |SMIN| without overflowing
  always_comb begin
    if (neg_q) begin
      fix_ov  = div_q > LIM_NEG;
      fix_val = fix_ov ? SMIN : -div_q[XLEN-1:0];
    end else begin
      fix_ov  = div_q > LIM_POS;
      fix_val = fix_ov ? SMAX : div_q[XLEN-1:0];
    end
  end

  f_fixed_div #(
    .XLEN      (XLEN),
    .FRAC      (FRAC),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= S_IDLE;
      oDONE   <= 1'b0;
      oRESULT <= '0;
      oRD     <= '0;
      oOV     <= 1'b0;
      oDZ     <= 1'b0;
      prod    <= '0;
      mop     <= OP_ADD;
      mc      <= '0;
      tag     <= '0;
      neg_q   <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            tag <= iRD;
            if (quick) begin
              oRESULT <= quick_val;
              oRD     <= iRD;
              oOV     <= quick_ov;
              oDZ     <= quick_dz;
              oDONE   <= 1'b1;
            end else if (iOP == OP_DIV) begin
              neg_q <= iA[XLEN-1] ^ iB[XLEN-1];
              state <= S_DIV;
            end else begin
              prod  <= a_ext * b_ext;
              mop   <= iOP;
              mc    <= iC;
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          oRESULT <= mul_val;
          oRD     <= tag;
          oOV     <= mul_ov;
          oDZ     <= 1'b0;
          oDONE   <= 1'b1;
          state   <= S_IDLE;
        end
        S_DIV: begin
          if (div_done) state <= S_FIX;
        end
        S_FIX: begin
          oRESULT <= fix_val;
          oRD     <= tag;
          oOV     <= fix_ov;
          oDZ     <= 1'b0;
          oDONE   <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fixed_alu.sv
// Directed, table-driven bench for f_fixed_alu (Q28.4) with hand-computed
// expectations plus sequences for back-to-back, busy-drop and reset-abort.
module tb_f_fixed_alu;
  import f_alu_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic [2:0]  iOP = 3'd0;
  logic [4:0]  iRD = 5'd0;
  logic [31:0] iA = '0, iB = '0, iC = '0;
  logic        oBUSY, oDONE, oOV, oDZ;
  logic [31:0] oRESULT;
  logic [4:0]  oRD;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, c;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ov, dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  f_fixed_alu #(.XLEN(32), .FRAC(4), .DIV_STEPS(36)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iOP(iOP), .iRD(iRD),
    .iA(iA), .iB(iB), .iC(iC), .oBUSY(oBUSY), .oDONE(oDONE),
    .oRESULT(oRESULT), .oRD(oRD), .oOV(oOV), .oDZ(oDZ)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, b, c,
                              input logic [4:0] rd, input logic [31:0] res,
                              input logic ov, dz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.rd = rd;
    v.res = res; v.ov = ov; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic busy1;
    @(negedge iCLK);
    iSTART = 1'b1; iOP = v.op; iA = v.a; iB = v.b; iC = v.c; iRD = v.rd;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    lat   = 1;
    busy1 = oBUSY;
    while (!oDONE && lat < 100) begin
      @(posedge iCLK); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d result", idx), oRESULT, v.res);
    check($sformatf("v%0d rd", idx), {27'd0, oRD}, {27'd0, v.rd});
    check($sformatf("v%0d ov", idx), {31'd0, oOV}, {31'd0, v.ov});
    check($sformatf("v%0d dz", idx), {31'd0, oDZ}, {31'd0, v.dz});
    check($sformatf("v%0d busy_n1", idx), {31'd0, busy1}, {31'd0, (v.lat > 1)});
    check($sformatf("v%0d busy_done", idx), {31'd0, oBUSY}, 32'd0);
  endtask

  initial begin
    int dones, lat, done_lat;
    logic [31:0] got_res;
    logic [4:0]  got_rd;

    repeat (3) @(posedge iCLK);
    #1;
    check("rst result", oRESULT, 32'd0);
    check("rst rd", {27'd0, oRD}, 32'd0);
    check("rst busy", {31'd0, oBUSY}, 32'd0);
    check("rst done", {31'd0, oDONE}, 32'd0);
    check("rst ov", {31'd0, oOV}, 32'd0);
    check("rst dz", {31'd0, oDZ}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;

    //                  op       a             b             c             rd     result        ov    dz    lat
    vecs.push_back(mk(OP_ADD,  32'h00000030, 32'h00000028, 32'h0,        5'd5,  32'h00000058, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_SUB,  32'h00000030, 32'h00000028, 32'h0,        5'd6,  32'h00000008, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_MUL,  32'h00000030, 32'h00000028, 32'h0,        5'd7,  32'h00000078, 1'b0, 1'b0, 2));
    vecs.push_back(mk(OP_MADD, 32'h00000030, 32'h00000028, 32'h00000010, 5'd8,  32'h00000088, 1'b0, 1'b0, 2));
    vecs.push_back(mk(OP_MSUB, 32'h00000030, 32'h00000028, 32'h00000010, 5'd9,  32'h00000068, 1'b0, 1'b0, 2));
    vecs.push_back(mk(OP_DIV,  32'h00000030, 32'h00000028, 32'h0,        5'd10, 32'h00000013, 1'b0, 1'b0, 38));
    vecs.push_back(mk(OP_DIV,  32'hFFFFFFD0, 32'h00000028, 32'h0,        5'd11, 32'hFFFFFFED, 1'b0, 1'b0, 38));
    vecs.push_back(mk(OP_DIV,  32'h00000010, 32'h00000000, 32'h0,        5'd12, 32'h7FFFFFFF, 1'b0, 1'b1, 1));
    vecs.push_back(mk(OP_DIV,  32'hFFFFFFF0, 32'h00000000, 32'h0,        5'd13, 32'h80000000, 1'b0, 1'b1, 1));
    vecs.push_back(mk(OP_ADD,  32'h7FFFFFF0, 32'h00000020, 32'h0,        5'd14, 32'h7FFFFFFF, 1'b1, 1'b0, 1));
    vecs.push_back(mk(OP_MUL,  32'h40000000, 32'h00000040, 32'h0,        5'd15, 32'h7FFFFFFF, 1'b1, 1'b0, 2));
    vecs.push_back(mk(OP_MIN,  32'hFFFFFFF0, 32'h00000010, 32'h0,        5'd16, 32'hFFFFFFF0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_MAX,  32'hFFFFFFF0, 32'h00000010, 32'h0,        5'd17, 32'h00000010, 1'b0, 1'b0, 1));
    vecs.push_back(mk(OP_DIV,  32'h80000000, 32'h00000010, 32'h0,        5'd18, 32'h80000000, 1'b0, 1'b0, 38));
    vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h00000001, 32'h0,        5'd19, 32'h80000000, 1'b1, 1'b0, 1));
    vecs.push_back(mk(OP_MSUB, 32'hFFFFFFF0, 32'h00000028, 32'h00000010, 5'd20, 32'hFFFFFFC8, 1'b0, 1'b0, 2));
    vecs.push_back(mk(OP_MUL,  32'hFFFFFFFF, 32'h00000001, 32'h0,        5'd21, 32'hFFFFFFFF, 1'b0, 1'b0, 2));
    vecs.push_back(mk(OP_DIV,  32'h00000010, 32'h00000030, 32'h0,        5'd22, 32'h00000005, 1'b0, 1'b0, 38));
    vecs.push_back(mk(OP_DIV,  32'hFFFFFFF0, 32'h00000030, 32'h0,        5'd23, 32'hFFFFFFFB, 1'b0, 1'b0, 38));
    vecs.push_back(mk(OP_DIV,  32'h7FFFFFFF, 32'h00000001, 32'h0,        5'd24, 32'h7FFFFFFF, 1'b1, 1'b0, 38));
    vecs.push_back(mk(OP_MAX,  32'h00000050, 32'h00000050, 32'h0,        5'd25, 32'h00000050, 1'b0, 1'b0, 1));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // back-to-back single-cycle ops
    @(negedge iCLK);
    iSTART = 1'b1; iOP = OP_ADD; iA = 32'h30; iB = 32'h28; iRD = 5'd5;
    @(posedge iCLK); #1;
    iOP = OP_SUB; iRD = 5'd6;
    check("b2b add done", {31'd0, oDONE}, 32'd1);
    check("b2b add result", oRESULT, 32'h58);
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    check("b2b sub done", {31'd0, oDONE}, 32'd1);
    check("b2b sub result", oRESULT, 32'h08);
    check("b2b sub rd", {27'd0, oRD}, 32'd6);
    @(posedge iCLK); #1;
    check("b2b idle done", {31'd0, oDONE}, 32'd0);

    // requests during a divide are dropped
    @(negedge iCLK);
    iSTART = 1'b1; iOP = OP_DIV; iA = 32'h30; iB = 32'h28; iRD = 5'd9;
    @(posedge iCLK); #1;
    iOP = OP_ADD; iA = 32'h1; iB = 32'h1; iRD = 5'd1;
    dones = 0; done_lat = 0; got_res = '0; got_rd = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) iSTART = 1'b0;
      if (oDONE) begin
        dones++;
        done_lat = k;
        got_res  = oRESULT;
        got_rd   = oRD;
      end
      @(posedge iCLK); #1;
    end
    check("drop done count", dones, 32'd1);
    check("drop latency", done_lat, 32'd38);
    check("drop result", got_res, 32'h13);
    check("drop rd", {27'd0, got_rd}, 32'd9);

    // reset in the middle of a divide
    @(negedge iCLK);
    iSTART = 1'b1; iOP = OP_DIV; iA = 32'h30; iB = 32'h28; iRD = 5'd3;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (9) begin
      @(posedge iCLK); #1;
    end
    check("abort busy before rst", {31'd0, oBUSY}, 32'd1);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b0;
    check("abort busy", {31'd0, oBUSY}, 32'd0);
    check("abort done", {31'd0, oDONE}, 32'd0);
    check("abort result", oRESULT, 32'd0);
    check("abort rd", {27'd0, oRD}, 32'd0);
    check("abort ov", {31'd0, oOV}, 32'd0);
    check("abort dz", {31'd0, oDZ}, 32'd0);
    iSTART = 1'b1; iOP = OP_ADD; iA = 32'h30; iB = 32'h28; iRD = 5'd4;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    check("post-rst add done", {31'd0, oDONE}, 32'd1);
    check("post-rst add result", oRESULT, 32'h58);
    check("post-rst add rd", {27'd0, oRD}, 32'd4);
    dones = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge iCLK); #1;
      if (oDONE) dones++;
    end
    check("abort stray done", dones, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
